// File: rtl/alu_ctrl_mdu.sv
// -----------------------------------------------------------------------------
// alu_ctrl_mdu
//
// ALU control decoder combined with an iterative RV32M multiply/divide unit.
// The decoder turns an op class plus instruction word into a 4-bit ALU control
// code. Multiply/divide requests run for WIDTH cycles: one shift-add or one
// restoring-division step per cycle, on operand magnitudes, with the sign
// fixed up on the final step. Division by zero and signed overflow skip the
// iteration and answer on the next cycle.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   AluOp               op class: 000 I, 001 S, 010 SB, 100 U, 101 R
//   inst                instruction word (funct3 = [14:12], funct7 = [31:25])
//   op_a, op_b          rs1 / rs2 operands for the MDU
//   in_valid/in_ready   request handshake; in_ready only while idle
//   out_valid/out_ready result handshake; result held until consumed
//   Alu_Control_Lines   registered ALU control code
//   is_mdu, mdu_result  result comes from the MDU / MDU result value
//   illegal             accepted request had no valid decode
//   busy                unit is not idle
// -----------------------------------------------------------------------------
module alu_ctrl_mdu #(
    parameter int WIDTH    = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       AluOp,
    input  logic [WIDTH-1:0] inst,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       Alu_Control_Lines,
    output logic             is_mdu,
    output logic [WIDTH-1:0] mdu_result,
    output logic             illegal,
    output logic             busy
);

    typedef enum logic [3:0] {
        CTRL_AND  = 4'b0000,
        CTRL_OR   = 4'b0001,
        CTRL_ADD  = 4'b0010,
        CTRL_SLL  = 4'b0011,
        CTRL_SLTU = 4'b0100,
        CTRL_SRL  = 4'b0101,
        CTRL_SUB  = 4'b0110,
        CTRL_SRA  = 4'b0111,
        CTRL_XOR  = 4'b1000,
        CTRL_BNE  = 4'b1001,
        CTRL_BEQ  = 4'b1010,
        CTRL_BLT  = 4'b1011,
        CTRL_BGE  = 4'b1100,
        CTRL_LUI  = 4'b1101,
        CTRL_SLT  = 4'b1110
    } ctrl_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int CW = $clog2(WIDTH);
    // Decode fields sit at fixed RV32 positions, so view the word as >= 32 bits.
    localparam int IW = (WIDTH < 32) ? 32 : WIDTH;
    localparam logic [6:0]       OPC_OP_IMM = 7'b0010011;
    localparam logic [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------ decode
    logic [IW-1:0] inst_w;
    logic [6:0]    opcode;
    logic [6:0]    funct7;
    logic [2:0]    funct3;
    logic          unused_inst_bits;

    assign inst_w           = IW'(inst);
    assign opcode           = inst_w[6:0];
    assign funct3           = inst_w[14:12];
    assign funct7           = inst_w[31:25];
    assign unused_inst_bits = ^{inst_w[24:15], inst_w[11:7]};

    ctrl_e dec_ctrl;
    logic  dec_illegal;
    logic  dec_mdu;

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can
        // leave one unassigned and infer a latch.
        dec_ctrl    = CTRL_ADD;
        dec_illegal = 1'b0;
        dec_mdu     = 1'b0;
        case (AluOp)
            3'b000: begin
                case (funct3)
                    3'b000:  dec_ctrl = CTRL_ADD;
                    3'b001:  dec_ctrl = CTRL_SLL;
                    // Loads share funct3 010 with SLTI; only OP-IMM compares.
                    3'b010:  dec_ctrl = (opcode == OPC_OP_IMM) ? CTRL_SLT : CTRL_ADD;
                    3'b011: begin
                        if (opcode == OPC_OP_IMM) dec_ctrl = CTRL_SLTU;
                        else                      dec_illegal = 1'b1;
                    end
                    3'b100:  dec_ctrl = CTRL_XOR;
                    3'b101:  dec_ctrl = inst_w[30] ? CTRL_SRA : CTRL_SRL;
                    3'b110:  dec_ctrl = CTRL_OR;
                    default: dec_ctrl = CTRL_AND;
                endcase
            end
            3'b001: dec_ctrl = CTRL_ADD;
            3'b100: dec_ctrl = CTRL_LUI;
            3'b010: begin
                case (funct3)
                    3'b000:  dec_ctrl = CTRL_BEQ;
                    3'b001:  dec_ctrl = CTRL_BNE;
                    3'b100:  dec_ctrl = CTRL_BLT;
                    3'b101:  dec_ctrl = CTRL_BGE;
                    default: dec_illegal = 1'b1;
                endcase
            end
            3'b101: begin
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  dec_ctrl = CTRL_ADD;
                            3'b001:  dec_ctrl = CTRL_SLL;
                            3'b010:  dec_ctrl = CTRL_SLT;
                            3'b011:  dec_ctrl = CTRL_SLTU;
                            3'b100:  dec_ctrl = CTRL_XOR;
                            3'b101:  dec_ctrl = CTRL_SRL;
                            3'b110:  dec_ctrl = CTRL_OR;
                            default: dec_ctrl = CTRL_AND;
                        endcase
                    end
                    7'b0100000: begin
                        case (funct3)
                            3'b000:  dec_ctrl = CTRL_SUB;
                            3'b101:  dec_ctrl = CTRL_SRA;
                            default: dec_illegal = 1'b1;
                        endcase
                    end
                    7'b0000001: begin
                        if (ENABLE_M) dec_mdu     = 1'b1;
                        else          dec_illegal = 1'b1;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // ------------------------------------------------------- MDU request setup
    // funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
    //         100 DIV, 101 DIVU, 110 REM,    111 REMU
    logic             a_signed;
    logic             b_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             div_ovf;
    logic             res_neg;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3)
            3'b001, 3'b100, 3'b110: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'b010:  a_signed = 1'b1;
            default: ;
        endcase
    end

    assign a_neg    = a_signed & op_a[WIDTH-1];
    assign b_neg    = b_signed & op_b[WIDTH-1];
    assign a_mag    = a_neg ? -op_a : op_a;
    assign b_mag    = b_neg ? -op_b : op_b;
    assign div_zero = funct3[2] && (op_b == '0);
    assign div_ovf  = ((funct3 == 3'b100) || (funct3 == 3'b110))
                      && (op_a == MOST_NEG) && (op_b == '1);
    // Remainder follows the dividend's sign; product and quotient the XOR.
    assign res_neg  = (funct3[2:1] == 2'b11) ? a_neg : (a_neg ^ b_neg);

    // ------------------------------------------------------------- registers
    state_e             state_q,   state_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    ctrl_e              ctrl_q,    ctrl_d;
    logic               illegal_q, illegal_d;
    logic               is_mdu_q,  is_mdu_d;
    logic [WIDTH-1:0]   res_q,     res_d;
    // acc: {partial product high, multiplier} or {partial remainder, dividend}
    logic [2*WIDTH-1:0] acc_q,     acc_d;
    // opnd: multiplicand or divisor magnitude
    logic [WIDTH-1:0]   opnd_q,    opnd_d;
    logic [2:0]         f3_q,      f3_d;
    logic               neg_q,     neg_d;

    // ------------------------------------------------------------ iteration
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (f3_q[2]) begin
            // Restoring step: keep the difference only when it did not borrow.
            if (!div_diff[WIDTH]) acc_step = {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
            else                  acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Sign-corrected result taken straight from the last step's output, so
    // the final step and result capture share the same cycle.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   mdu_final;

    always_comb begin
        prod_fix = neg_q ? -acc_step : acc_step;
        quo_fix  = neg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
        rem_fix  = neg_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
        case (f3_q)
            3'b000:                 mdu_final = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: mdu_final = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         mdu_final = quo_fix;
            default:                mdu_final = rem_fix;
        endcase
    end

    // ----------------------------------------------------------------- FSM
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        illegal_d = illegal_q;
        is_mdu_d  = is_mdu_q;
        res_d     = res_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        f3_d      = f3_q;
        neg_d     = neg_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ctrl_d    = dec_ctrl;
                    illegal_d = dec_illegal;
                    is_mdu_d  = dec_mdu;
                    res_d     = '0;
                    state_d   = S_DONE;
                    if (dec_mdu) begin
                        f3_d  = funct3;
                        neg_d = res_neg;
                        if (div_zero) begin
                            res_d = funct3[1] ? op_a : '1;
                        end else if (div_ovf) begin
                            res_d = funct3[1] ? '0 : op_a;
                        end else begin
                            state_d = S_CALC;
                            cnt_d   = CW'(WIDTH - 1);
                            acc_d   = {{WIDTH{1'b0}}, a_mag};
                            opnd_d  = b_mag;
                        end
                    end
                end
            end
            S_CALC: begin
                acc_d = acc_step;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    res_d   = mdu_final;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath registers are reset along with the control
            // state so an aborted operation leaves nothing stale behind.
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ctrl_q    <= CTRL_ADD;
            illegal_q <= 1'b0;
            is_mdu_q  <= 1'b0;
            res_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            f3_q      <= '0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            is_mdu_q  <= is_mdu_d;
            res_q     <= res_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            f3_q      <= f3_d;
            neg_q     <= neg_d;
        end
    end

    // -------------------------------------------------------------- outputs
    assign in_ready          = (state_q == S_IDLE);
    assign out_valid         = (state_q == S_DONE);
    assign busy              = (state_q != S_IDLE);
    assign Alu_Control_Lines = ctrl_q;
    assign is_mdu            = is_mdu_q;
    assign illegal           = illegal_q;
    assign mdu_result        = res_q;

endmodule
